spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_clk_gen.sv | 27 ++
 rtl/spi_master.sv | 111 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master types (FSM states, mode encodings {CPOL,CPHA}, default divider and width)
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE_S} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter; clk/rst_n (sync, active-low), en in, registered one-cycle tick out every CLK_DIV cycles, cleared while en is low
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  assign tick = tick_q;
  always_comb begin
    tick_d = en && cnt_q == CW'(CLK_DIV - 1);
    cnt_d = !en ? '0 : tick_d ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: SPI master, modes 0-3, MSB first; START/TX_DATA/MODE request in, BUSY/DONE/RX_DATA status out, SS/SCK/MOSI out and MISO in on the bus
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic [1:0]        MODE,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  state_t state_q, state_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [1:0] mode_q, mode_d;
  logic sck_q, sck_d, mosi_q, mosi_d, tick, lead, shift_ev, samp_ev;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (CLK),
    .rst_n(RST_N),
    .en   (BUSY),
    .tick (tick)
  );
  assign BUSY = state_q inside {SETUP, XFER, HOLD};
  assign DONE = state_q == DONE_S;
  assign SS = ~BUSY;
  assign SCK = state_q == IDLE ? MODE[1] : sck_q;
  assign MOSI = mosi_q;
  assign RX_DATA = rx_data_q;
  assign lead = ~edge_q[0];
  assign shift_ev = tick && state_q == XFER && (mode_q[0] == lead);
  assign samp_ev = tick && state_q == XFER && (mode_q[0] != lead);
  always_comb begin
    state_d = state_q;
    edge_d = edge_q;
    mode_d = mode_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    tx_d = tx_q;
    rx_d = rx_q;
    rx_data_d = rx_data_q;
    unique case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        edge_d = '0;
        if (START) begin
          state_d = SETUP;
          mode_d = MODE;
          sck_d = MODE[1];
          rx_d = '0;
          mosi_d = MODE[0] ? 1'b0 : TX_DATA[DATA_W-1];
          tx_d = MODE[0] ? TX_DATA : TX_DATA << 1;
        end
      end
      SETUP: state_d = tick ? XFER : SETUP;
      XFER: begin
        if (tick) begin
          sck_d = ~sck_q;
          edge_d = edge_q + 1'b1;
          state_d = edge_q == EW'(2 * DATA_W - 1) ? HOLD : XFER;
        end
      end
      HOLD: begin
        if (tick) begin
          state_d = DONE_S;
          rx_data_d = rx_q;
        end
      end
      DONE_S: begin
        state_d = IDLE;
        mosi_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (shift_ev) begin
      mosi_d = tx_q[DATA_W-1];
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
    if (samp_ev) rx_d = {rx_q[DATA_W-2:0], MISO};
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      edge_q <= '0;
      mode_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      tx_q <= '0;
      rx_q <= '0;
      rx_data_q <= '0;
    end else begin
      state_q <= state_d;
      edge_q <= edge_d;
      mode_q <= mode_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      rx_data_q <= rx_data_d;
    end
  end
endmodule
